// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared constants and the bundle-width helper for fetch_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int INSTR_W        = 32;
    localparam int ADDR_W_DEFAULT = 32;
    localparam int DEPTH_DEFAULT  = 2;

    function automatic int bundle_w(input int cores);
        return INSTR_W * cores;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_fifo
//  Description : Synchronous FIFO carrying {bundle, pc}; flush dominates push.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_L = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             w_do_pop;

    assign w_do_pop  = pop && (count_q != '0);
    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (w_do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, w_do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // The upstream credit rule keeps count + inflight <= DEPTH, so a full FIFO never sees a push.
    a_no_push_when_full: assert property (
        @(posedge clk) disable iff (!rst_n) (push && !flush) |-> (count_q != DEPTH_L)
    );

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : PC owner feeding instructionmemory; buffers returned bundles
//                for decode. Optional counters under macro FETCH_PERF_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                CORES    = 1,
    parameter int                ADDR_W   = ADDR_W_DEFAULT,
    parameter logic [ADDR_W-1:0] PC_RESET = '0,
    parameter int                DEPTH    = DEPTH_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst_n,
    output logic [ADDR_W-1:0]            imem_addr,
    input  logic [bundle_w(CORES)-1:0]   imem_data,
    input  logic                         branch_valid,
    input  logic [ADDR_W-1:0]            branch_target,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [bundle_w(CORES)-1:0]   out_bundle,
    output logic [ADDR_W-1:0]            out_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]                  perf_fetched,
    output logic [31:0]                  perf_stall
`endif
);

    localparam int BUNDLE_W = bundle_w(CORES);
    localparam int ENTRY_W  = BUNDLE_W + ADDR_W;
    localparam int CNT_W    = $clog2(DEPTH) + 1;
    localparam logic [CNT_W:0] DEPTH_L = (CNT_W + 1)'(DEPTH);

    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  inflight_pc_q, inflight_pc_d;
    logic               inflight_q, inflight_d;

    logic [CNT_W-1:0]   w_count;
    logic [CNT_W:0]     w_occupancy;
    logic [ENTRY_W-1:0] w_head;
    logic               w_pop;
    logic               w_issue;

    assign imem_addr  = pc_q;
    assign out_valid  = (w_count != '0);
    assign w_pop      = out_valid && out_ready;
    assign out_bundle = w_head[ENTRY_W-1:ADDR_W];
    assign out_pc     = w_head[ADDR_W-1:0];

    // A pop this edge frees a slot, so a full pipeline can still issue and sustain 1 bundle/cycle.
    always_comb begin
        w_occupancy   = {1'b0, w_count} + (CNT_W + 1)'(inflight_q);
        w_issue       = !branch_valid && ((w_occupancy < DEPTH_L) || w_pop);
        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        if (branch_valid) begin
            pc_d = branch_target;
        end else if (w_issue) begin
            pc_d          = pc_q + ADDR_W'(1);
            inflight_d    = 1'b1;
            inflight_pc_d = pc_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= PC_RESET;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    // A redirect flushes the FIFO and drops the read returning on the same edge.
    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight_q),
        .push_data ({imem_data, inflight_pc_q}),
        .pop       (w_pop),
        .flush     (branch_valid),
        .head_data (w_head),
        .count     (w_count)
    );

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_fetched_d = perf_fetched_q;
        perf_stall_d   = perf_stall_q;
        if (w_pop && (perf_fetched_q != '1)) begin
            perf_fetched_d = perf_fetched_q + 32'd1;
        end
        if (out_valid && !out_ready && (perf_stall_q != '1)) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_stall_q   <= perf_stall_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Cycle table plus pc/bundle scoreboard for fetch_unit (CORES=1 and CORES=2).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        out_ready;
    logic        branch_valid;
    logic [31:0] branch_target;

    logic [31:0] imem_addr1, imem_data1, out_bundle1, out_pc1;
    logic        out_valid1;
    logic [31:0] imem_addr2, out_pc2;
    logic [63:0] imem_data2, out_bundle2;
    logic        out_valid2;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched1, perf_stall1, perf_fetched2, perf_stall2;
`endif

    always #5 clk = ~clk;

    fetch_unit #(.CORES(1)) u_dut1 (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_addr     (imem_addr1),
        .imem_data     (imem_data1),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .out_valid     (out_valid1),
        .out_ready     (out_ready),
        .out_bundle    (out_bundle1),
        .out_pc        (out_pc1)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched  (perf_fetched1),
        .perf_stall    (perf_stall1)
`endif
    );

    fetch_unit #(.CORES(2)) u_dut2 (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_addr     (imem_addr2),
        .imem_data     (imem_data2),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .out_valid     (out_valid2),
        .out_ready     (out_ready),
        .out_bundle    (out_bundle2),
        .out_pc        (out_pc2)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched  (perf_fetched2),
        .perf_stall    (perf_stall2)
`endif
    );

    // Instruction memory models: one-cycle registered read of a hashed word.
    function automatic logic [31:0] word1(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [63:0] word2(input logic [31:0] a);
        return {word1(a) ^ 32'hFFFF_0000, word1(a + 32'd7)};
    endfunction

    always @(posedge clk) begin
        imem_data1 <= word1(imem_addr1);
        imem_data2 <= word2(imem_addr2);
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard of pcs decode should receive, in order.
    logic [31:0] sb_q[$];
    logic [31:0] sb_next;

    task automatic sb_fill();
        while (sb_q.size() < 4) begin
            sb_q.push_back(sb_next);
            sb_next = sb_next + 32'd1;
        end
    endtask

    task automatic sb_restart(input logic [31:0] start);
        sb_q.delete();
        sb_next = start;
        sb_fill();
    endtask

    typedef struct {
        bit          rst;
        bit          ready;
        bit          br;
        logic [31:0] tgt;
        bit          ev;
        logic [31:0] ea;
        logic [31:0] ep;
    } vec_t;

    function automatic vec_t mk(input bit rst, input bit ready, input bit br, input logic [31:0] tgt,
                                input bit ev, input logic [31:0] ea, input logic [31:0] ep);
        vec_t v;
        v.rst = rst; v.ready = ready; v.br = br; v.tgt = tgt;
        v.ev = ev; v.ea = ea; v.ep = ep;
        return v;
    endfunction

    vec_t vecs[$];
    int   exp_fetched;
    int   exp_stall;

    initial begin
        logic [31:0] exp_pc;
        // rst ready br target | valid addr pc
        vecs.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,        32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h1,        32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1, 32'h2,        32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1, 32'h3,        32'h1));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1, 32'h4,        32'h2));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h1,        32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'h2,        32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'h2,        32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'h2,        32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1, 32'h2,        32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1, 32'h3,        32'h1));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1, 32'h4,        32'h2));
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'h5,        32'h3));
        vecs.push_back(mk(0, 0, 1, 32'h40,       1, 32'h5,        32'h3));
        vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h40,       32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h41,       32'h0));
        vecs.push_back(mk(0, 1, 1, 32'h3,        1, 32'h42,       32'h40));
        vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h3,        32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h4,        32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1, 32'h5,        32'h3));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1, 32'h6,        32'h4));
        vecs.push_back(mk(0, 1, 1, 32'hFFFF_FFFF, 1, 32'h7,       32'h5));
        vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'hFFFF_FFFF, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1, 32'h1,        32'hFFFF_FFFF));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1, 32'h2,        32'h0));
        vecs.push_back(mk(0, 1, 1, 32'h100,      1, 32'h3,        32'h1));
        vecs.push_back(mk(0, 1, 1, 32'h200,      0, 32'h100,      32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h200,      32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h201,      32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1, 32'h202,      32'h200));

        rst_n         = 1'b1;
        out_ready     = 1'b0;
        branch_valid  = 1'b0;
        branch_target = 32'h0;
        exp_fetched   = 0;
        exp_stall     = 0;
        sb_restart(32'h0);
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            rst_n         = !vecs[i].rst;
            out_ready     = vecs[i].ready;
            branch_valid  = vecs[i].br;
            branch_target = vecs[i].tgt;
            @(negedge clk);

            check($sformatf("v%0d.valid", i), 64'(out_valid1), 64'(vecs[i].ev));
            check($sformatf("v%0d.addr", i), 64'(imem_addr1), 64'(vecs[i].ea));
            check($sformatf("v%0d.valid2", i), 64'(out_valid2), 64'(vecs[i].ev));
            check($sformatf("v%0d.addr2", i), 64'(imem_addr2), 64'(vecs[i].ea));
            if (vecs[i].ev) begin
                check($sformatf("v%0d.pc", i), 64'(out_pc1), 64'(vecs[i].ep));
                check($sformatf("v%0d.bundle", i), 64'(out_bundle1), 64'(word1(vecs[i].ep)));
                check($sformatf("v%0d.bundle2", i), out_bundle2, word2(vecs[i].ep));
            end

            if (vecs[i].rst) begin
                check($sformatf("v%0d.rst_pc", i), 64'(out_pc1), 64'h0);
                check($sformatf("v%0d.rst_bundle", i), 64'(out_bundle1), 64'h0);
                check($sformatf("v%0d.rst_bundle2", i), out_bundle2, 64'h0);
`ifdef FETCH_PERF_EN
                check($sformatf("v%0d.rst_perf_fetched", i), 64'(perf_fetched1), 64'h0);
                check($sformatf("v%0d.rst_perf_stall", i), 64'(perf_stall1), 64'h0);
`endif
                exp_fetched = 0;
                exp_stall   = 0;
                sb_restart(32'h0);
            end else begin
                if (vecs[i].ev && vecs[i].ready) exp_fetched++;
                if (vecs[i].ev && !vecs[i].ready) exp_stall++;
                if (out_valid1 && out_ready) begin
                    exp_pc = sb_q.pop_front();
                    check($sformatf("sb%0d.pc", i), 64'(out_pc1), 64'(exp_pc));
                    check($sformatf("sb%0d.bundle", i), 64'(out_bundle1), 64'(word1(exp_pc)));
                    check($sformatf("sb%0d.bundle2", i), out_bundle2, word2(exp_pc));
                    sb_fill();
                end
                if (branch_valid) begin
                    sb_restart(branch_target);
                end
            end

            @(posedge clk);
            #1;
        end

        @(negedge clk);
`ifdef FETCH_PERF_EN
        check("perf_fetched", 64'(perf_fetched1), 64'(exp_fetched));
        check("perf_stall", 64'(perf_stall1), 64'(exp_stall));
        check("perf_fetched2", 64'(perf_fetched2), 64'(exp_fetched));
        check("perf_stall2", 64'(perf_stall2), 64'(exp_stall));
`endif
        check("final_valid", 64'(out_valid1), 64'h1);
        check("final_pc", 64'(out_pc1), 64'h201);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Upstream neighbour of instructionmemory: owns the program counter, drives the memory's word address, and captures the CORES×32-bit bundle the memory returns one cycle later.
Presents bundles to decode through a valid/ready handshake.
A small FIFO absorbs memory latency so decode back-pressure never loses an in-flight read.
Branch redirects flush all fetched and in-flight work.

Parameters:
CORES, 1, instructions per bundle; bundle width = 32*CORES
ADDR_W, 32, word-address width (PC increments by 1 per bundle)
PC_RESET, 0, PC value after reset
DEPTH, 2, FIFO entries (power of two, >= 2)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_addr  out  ADDR_W  word address to instructionmemory.address
imem_data  in  32*CORES  instructionmemory.dataOut
branch_valid  in  1  redirect request this cycle
branch_target  in  ADDR_W  redirect word address
out_valid  out  1  bundle available to decode
out_ready  in  1  decode accepts bundle
out_bundle  out  32*CORES  instruction bundle
out_pc  out  ADDR_W  word address of out_bundle

Behaviour:
- Reset (async assert, sync-release use): pc=PC_RESET, imem_addr=PC_RESET, FIFO count=0, inflight=0, out_valid=0, out_bundle=0, out_pc=0.
- Memory contract: address sampled at a rising edge; dataOut valid after that edge, stable until the next edge.
- imem_addr is the pc register output.
- pop = out_valid & out_ready.
- issue = !branch_valid & ((count + inflight) < DEPTH | pop).
- On issue at edge k: inflight<=1, inflight_pc<=pc, pc<=pc+1 (mod 2^ADDR_W).
- Without issue: inflight<=0 and pc holds.
- At edge k+1, if inflight=1: push {imem_data, inflight_pc} into the FIFO.
- Latency: bundle for pc=A is on out_bundle two edges after A is on imem_addr. Steady-state throughput is 1 bundle/cycle when out_ready=1.
- FIFO head drives out_bundle/out_pc; out_valid = (count != 0).
- While out_valid=1 and out_ready=0, out_bundle/out_pc hold.
- Simultaneous push and pop: count unchanged, order preserved.
- Push when full is impossible by the credit rule; assertion required.
- Redirect (branch_valid=1 at an edge):
  - pc<=branch_target; FIFO cleared; inflight<=0.
  - A pop handshaking on that same edge is complete (consumer keeps it).
  - out_valid=0 on the following cycle.
  - First new bundle (pc=branch_target) appears two edges after the redirect edge.
  - Back-to-back redirects: last one wins.
- PC wrap from 2^ADDR_W-1 to 0 is legal and silent.
- Reset mid-operation: all state returns to reset values immediately; in-flight data is discarded.

Optional Feature:
FETCH_PERF_EN.
- Defined: adds ports perf_fetched (out, 32) and perf_stall (out, 32), both reset to 0.
  - perf_fetched increments on every pop.
  - perf_stall increments on every cycle with out_valid=1 & out_ready=0.
  - Both saturate at 2^32-1.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package fetch_pkg holds INSTR_W=32, default ADDR_W/DEPTH, and a bundle-width helper function of CORES.
- One natural sub-module: fetch_fifo. It is a parameterised synchronous FIFO carrying {bundle, pc}, with push, pop, flush (flush dominates push) and count output.
- The PC, credit logic and inflight register stay in fetch_unit.

Test Plan:
- Reset, out_ready=1, CORES=1, memory preloaded: imem_addr goes 0,1,2,3 on consecutive cycles; out_pc 0,1,2 on cycles 2,3,4; out_bundle matches memory word for word.
- out_ready=0 from cycle 0: FIFO fills to DEPTH=2; imem_addr stalls at 2; out_pc holds 0. Releasing out_ready yields 0,1,2 with no gap and no duplicate.
- branch_valid with target 0x40 while FIFO holds 2 entries: next cycle out_valid=0; out_pc=0x40 two edges later; no stale pc (1,2,3) ever emitted.
- Branch on the same edge as a pop of pc=5: pc 5 is counted as consumed; the next emitted out_pc is the target.
- CORES=2: out_bundle is 64 bits; the bundle at address 3 equals the memory's 64-bit word 3.
- FETCH_PERF_EN defined: 10 pops and 4 stall cycles give perf_fetched=10 and perf_stall=4.
